evg_event_arbiter: RTL and testbench

Per-cycle scheduler that shares the single 8-bit event-code slot of the event generator transmit link between heartbeat, PPS seconds-marker, sequencer, hardware-trigger and time-of-day (ToD) shift requesters. Runs entirely in the transmit clock domain and feeds the event-code byte to the link encoder; distributed-bus bits are not handled here. Exactly one event code leaves per clock; 0x00 means no event.

---
 rtl/evg_event_pkg.sv | 15 +
 rtl/evg_event_arbiter_if.sv | 11 +
 rtl/evg_rr_arbiter.sv | 43 ++++
 rtl/evg_event_arbiter.sv | 136 +++++++++++++
 tb/tb_evg_event_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/evg_event_pkg.sv
// Event-code constants and ToD shifter state type shared by the event arbiter slice.
package evg_event_pkg;

  localparam logic [7:0] EVCODE_NULL      = 8'h00;
  localparam logic [7:0] EVCODE_SHIFT0    = 8'h70;
  localparam logic [7:0] EVCODE_SHIFT1    = 8'h71;
  localparam logic [7:0] EVCODE_HEARTBEAT = 8'h7A;
  localparam logic [7:0] EVCODE_SECONDS   = 8'h7D;

  typedef enum logic {
    TOD_IDLE,
    TOD_SHIFT
  } todState_t;

endpackage

// File: rtl/evg_event_arbiter_if.sv
// Sequencer code handshake into the event arbiter.
interface evg_event_arbiter_if;

  logic       evgSeqValid;
  logic [7:0] evgSeqCode;
  logic       evgSeqReady;

  modport master (output evgSeqValid, output evgSeqCode, input evgSeqReady);
  modport slave  (input evgSeqValid, input evgSeqCode, output evgSeqReady);

endinterface

// File: rtl/evg_rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant, pointer moves to one past the winner.
module evg_rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptrNext;
  logic          hit;

  // First pass searches from the pointer upward, second pass wraps to index 0.
  always_comb begin
    grant   = '0;
    ptrNext = ptr;
    hit     = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!hit && req[i] && (PW'(i) >= ptr)) begin
        hit      = 1'b1;
        grant[i] = 1'b1;
        ptrNext  = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!hit && req[i]) begin
        hit      = 1'b1;
        grant[i] = 1'b1;
        ptrNext  = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= '0;
    else     ptr <= ptrNext;
  end

endmodule

// File: rtl/evg_event_arbiter.sv
// Per-cycle event-code slot scheduler: heartbeat, PPS, sequencer, hardware triggers
// and the ToD seconds shifter share one registered 8-bit code per transmit clock.
module evg_event_arbiter
  import evg_event_pkg::*;
#(
  parameter int unsigned HARDWARE_TRIGGER_COUNT = 4,
  parameter int unsigned TOD_SECONDS_WIDTH      = 32,
  parameter int unsigned TOD_GAP                = 2
) (
  input  logic                                  evgTxClk,
  input  logic                                  evgTxReset,
  input  logic                                  evgHeartbeatRequest,
  input  logic                                  evgPPSmarker,
  input  logic [TOD_SECONDS_WIDTH-1:0]          evgSecondsNext,
  evg_event_arbiter_if.slave                    seq,
  input  logic [HARDWARE_TRIGGER_COUNT-1:0]     evgHwRequest,
  input  logic [8*HARDWARE_TRIGGER_COUNT-1:0]   evgHwCodes,
  input  logic                                  evgStatusClear,
  output logic [7:0]                            evgEventCode,
  output logic [HARDWARE_TRIGGER_COUNT-1:0]     evgHwDropped,
  output logic                                  evgTodOverrun,
  output logic                                  evgTodBusy
);

  localparam int unsigned N   = HARDWARE_TRIGGER_COUNT;
  localparam int unsigned W   = TOD_SECONDS_WIDTH;
  localparam int unsigned BCW = $clog2(W + 1);
  localparam logic [3:0]  GAP = 4'(TOD_GAP);

  logic           hbPend, ppsPend;
  logic [N-1:0]   hwPend, hwReq, hwGrant;
  logic           seqReady, grantHb, grantPps, grantSeq, grantShift;
  logic [7:0]     hwCode, codeNext;
  logic [W-1:0]   shadow, shiftReg, shiftNext;
  logic [BCW-1:0] bitCnt, bitCntNext;
  logic [3:0]     gapCnt, gapCntNext;
  todState_t      state, stateNext;

  // Each priority level only sees requests when everything above it is idle.
  always_comb begin
    grantHb    = hbPend;
    grantPps   = !hbPend && ppsPend;
    seqReady   = !hbPend && !ppsPend;
    grantSeq   = seqReady && seq.evgSeqValid;
    hwReq      = (seqReady && !seq.evgSeqValid) ? hwPend : '0;
    grantShift = (state == TOD_SHIFT) && (gapCnt == 4'd0) && seqReady
                 && !seq.evgSeqValid && !(|hwPend);
  end

  evg_rr_arbiter #(.N(N)) hwArb (
    .clk   (evgTxClk),
    .rst   (evgTxReset),
    .req   (hwReq),
    .grant (hwGrant)
  );

  always_comb begin
    hwCode = EVCODE_NULL;
    for (int unsigned i = 0; i < N; i++) begin
      if (hwGrant[i]) hwCode = evgHwCodes[8*i +: 8];
    end
    codeNext = EVCODE_NULL;
    if (grantHb)         codeNext = EVCODE_HEARTBEAT;
    else if (grantPps)   codeNext = EVCODE_SECONDS;
    else if (grantSeq)   codeNext = seq.evgSeqCode;
    else if (|hwGrant)   codeNext = hwCode;
    else if (grantShift) codeNext = shiftReg[W-1] ? EVCODE_SHIFT1 : EVCODE_SHIFT0;
  end

  // A fresh 0x7D always reloads, abandoning any bits still queued.
  always_comb begin
    stateNext  = state;
    shiftNext  = shiftReg;
    bitCntNext = bitCnt;
    gapCntNext = gapCnt;
    case (state)
      TOD_IDLE: begin
        if (grantPps) begin
          stateNext  = TOD_SHIFT;
          shiftNext  = shadow;
          bitCntNext = BCW'(W);
          gapCntNext = '0;
        end
      end
      TOD_SHIFT: begin
        if (grantPps) begin
          shiftNext  = shadow;
          bitCntNext = BCW'(W);
          gapCntNext = '0;
        end else if (grantShift) begin
          shiftNext  = shiftReg << 1;
          bitCntNext = bitCnt - 1'b1;
          gapCntNext = GAP;
          if (bitCnt == BCW'(1)) stateNext = TOD_IDLE;
        end else if (gapCnt != 4'd0) begin
          gapCntNext = gapCnt - 1'b1;
        end
      end
      default: stateNext = TOD_IDLE;
    endcase
  end

  assign evgTodBusy      = (state == TOD_SHIFT) || ppsPend;
  assign seq.evgSeqReady = seqReady;

  always_ff @(posedge evgTxClk or posedge evgTxReset) begin
    if (evgTxReset) begin
      hbPend        <= 1'b0;
      ppsPend       <= 1'b0;
      hwPend        <= '0;
      shadow        <= '0;
      shiftReg      <= '0;
      bitCnt        <= '0;
      gapCnt        <= '0;
      state         <= TOD_IDLE;
      evgEventCode  <= EVCODE_NULL;
      evgHwDropped  <= '0;
      evgTodOverrun <= 1'b0;
    end else begin
      hbPend        <= evgHeartbeatRequest | (hbPend & ~grantHb);
      ppsPend       <= evgPPSmarker | (ppsPend & ~grantPps);
      hwPend        <= evgHwRequest | (hwPend & ~hwGrant);
      if (evgPPSmarker) shadow <= evgSecondsNext;
      shiftReg      <= shiftNext;
      bitCnt        <= bitCntNext;
      gapCnt        <= gapCntNext;
      state         <= stateNext;
      evgEventCode  <= codeNext;
      evgHwDropped  <= (evgStatusClear ? '0 : evgHwDropped)
                       | (evgHwRequest & hwPend & ~hwGrant);
      evgTodOverrun <= (evgStatusClear ? 1'b0 : evgTodOverrun)
                       | (evgPPSmarker & evgTodBusy);
    end
  end

endmodule

// File: tb/tb_evg_event_arbiter.sv
// Randomized and scripted stimulus for evg_event_arbiter against a queue-based reference model.
module tb_evg_event_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int GAP = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           hbReq, ppsReq, clr;
  logic [W-1:0]   secs;
  logic [N-1:0]   hwReq;
  logic [8*N-1:0] hwCodes;
  logic [7:0]     evCode;
  logic [N-1:0]   hwDropped;
  logic           todOverrun, todBusy;

  evg_event_arbiter_if seqIf ();

  evg_event_arbiter #(
    .HARDWARE_TRIGGER_COUNT (N),
    .TOD_SECONDS_WIDTH      (W),
    .TOD_GAP                (GAP)
  ) dut (
    .evgTxClk            (clk),
    .evgTxReset          (rst),
    .evgHeartbeatRequest (hbReq),
    .evgPPSmarker        (ppsReq),
    .evgSecondsNext      (secs),
    .seq                 (seqIf.slave),
    .evgHwRequest        (hwReq),
    .evgHwCodes          (hwCodes),
    .evgStatusClear      (clr),
    .evgEventCode        (evCode),
    .evgHwDropped        (hwDropped),
    .evgTodOverrun       (todOverrun),
    .evgTodBusy          (todBusy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: flags as booleans, ToD bits as a queue, gap as a countdown.
  bit         mHb, mPps, mOvr;
  bit [N-1:0] mHw, mDrop;
  int         mPtr, mGap;
  bit [W-1:0] mShadow;
  bit         todQ[$];
  bit [7:0]   mCode;
  bit [7:0]   seen[$];

  task automatic modelReset();
    mHb = 0; mPps = 0; mOvr = 0; mHw = '0; mDrop = '0;
    mPtr = 0; mGap = 0; mShadow = '0; mCode = 8'h00;
    todQ.delete();
  endtask

  task automatic modelStep(input bit hb, input bit pps, input bit [W-1:0] s, input bit sv,
                           input bit [7:0] sc, input bit [N-1:0] hw, input bit cl);
    bit gHb = 0, gPps = 0, shifted = 0, busy;
    int hwIdx = -1;
    bit [7:0] code = 8'h00;
    busy = (todQ.size() > 0) || mPps;
    if (mHb) begin
      gHb = 1; code = 8'h7A;
    end else if (mPps) begin
      gPps = 1; code = 8'h7D;
    end else if (sv) begin
      code = sc;
    end else if (mHw != '0) begin
      for (int k = 0; k < N; k++) begin
        int idx = (mPtr + k) % N;
        if (hwIdx < 0 && mHw[idx]) hwIdx = idx;
      end
      code = hwCodes[8*hwIdx +: 8];
    end else if (todQ.size() > 0 && mGap == 0) begin
      shifted = 1;
      code = todQ[0] ? 8'h71 : 8'h70;
    end
    if (cl) begin mDrop = '0; mOvr = 0; end
    for (int i = 0; i < N; i++)
      if (hw[i] && mHw[i] && hwIdx != i) mDrop[i] = 1;
    if (pps && busy) mOvr = 1;
    if (gPps) begin
      todQ.delete();
      for (int b = W - 1; b >= 0; b--) todQ.push_back(mShadow[b]);
      mGap = 0;
    end else if (shifted) begin
      void'(todQ.pop_front());
      mGap = GAP;
    end else if (todQ.size() > 0 && mGap > 0) begin
      mGap--;
    end
    if (pps) mShadow = s;
    mHb  = hb  || (mHb && !gHb);
    mPps = pps || (mPps && !gPps);
    for (int i = 0; i < N; i++) mHw[i] = hw[i] || (mHw[i] && hwIdx != i);
    if (hwIdx >= 0) mPtr = (hwIdx + 1) % N;
    mCode = code;
  endtask

  task automatic checkAll();
    checkEq("code", evCode, mCode);
    checkEq("ready", seqIf.evgSeqReady, !mHb && !mPps);
    checkEq("busy", todBusy, (todQ.size() > 0) || mPps);
    checkEq("dropped", hwDropped, mDrop);
    checkEq("overrun", todOverrun, mOvr);
  endtask

  // Called at a negedge: drive, step model, clock, then compare at the next negedge.
  task automatic cycle(input bit hb, input bit pps, input bit [W-1:0] s, input bit sv,
                       input bit [7:0] sc, input bit [N-1:0] hw, input bit cl);
    hbReq = hb; ppsReq = pps; secs = s; seqIf.evgSeqValid = sv; seqIf.evgSeqCode = sc;
    hwReq = hw; clr = cl;
    modelStep(hb, pps, s, sv, sc, hw, cl);
    @(negedge clk);
    checkAll();
    if (evCode != 8'h00) seen.push_back(evCode);
  endtask

  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, 8'h00, '0, 0);
  endtask

  int lastSec, secCount, shiftCount, cyc;
  logic [W-1:0] valB;

  initial begin
    hwCodes = {8'h13, 8'h12, 8'h11, 8'h10};
    hbReq = 0; ppsReq = 0; secs = '0; hwReq = '0; clr = 0;
    seqIf.evgSeqValid = 0; seqIf.evgSeqCode = 8'h00;
    rst = 1;
    modelReset();
    repeat (2) @(negedge clk);
    checkEq("rstCode", evCode, 8'h00);
    checkEq("rstReady", seqIf.evgSeqReady, 1'b1);
    rst = 0;
    runIdle(5);

    // Simultaneous heartbeat, PPS and sequencer code.
    seen.delete();
    cycle(1, 1, 32'h8000_0001, 1, 8'h21, '0, 0);
    checkEq("simSeq", evCode, 8'h21);
    runIdle(1);
    checkEq("simHb", evCode, 8'h7A);
    runIdle(1);
    checkEq("simPps", evCode, 8'h7D);
    runIdle(120);
    checkEq("todLen", seen.size(), 35);
    if (seen.size() == 35) begin
      for (int k = 0; k < 32; k++)
        checkEq("todBit", seen[3 + k], (k == 0 || k == 31) ? 8'h71 : 8'h70);
    end
    checkEq("todIdle", todBusy, 1'b0);

    // Round-robin over all triggers, trigger 0 re-requested on its own grant edge.
    seen.delete();
    cycle(0, 0, '0, 0, 8'h00, 4'hF, 0);
    cycle(0, 0, '0, 0, 8'h00, 4'h1, 0);
    runIdle(8);
    checkEq("rrLen", seen.size(), 5);
    if (seen.size() == 5) begin
      checkEq("rr0", seen[0], 8'h10);
      checkEq("rr1", seen[1], 8'h11);
      checkEq("rr2", seen[2], 8'h12);
      checkEq("rr3", seen[3], 8'h13);
      checkEq("rr4", seen[4], 8'h10);
    end
    checkEq("rrNoDrop", hwDropped, 4'h0);
    cycle(0, 0, '0, 1, 8'h33, 4'h2, 0);
    cycle(0, 0, '0, 1, 8'h34, 4'h2, 0);
    checkEq("dropSet", hwDropped, 4'h2);
    cycle(0, 0, '0, 0, 8'h00, '0, 1);
    checkEq("dropClr", hwDropped, 4'h0);
    runIdle(4);

    // Second PPS mid-sequence: overrun, reload with the new value.
    seen.delete();
    valB = 32'hA5C3_0F96;
    cycle(0, 1, 32'h1234_5678, 0, 8'h00, '0, 0);
    runIdle(9);
    cycle(0, 1, valB, 0, 8'h00, '0, 0);
    checkEq("ovrSet", todOverrun, 1'b1);
    runIdle(120);
    lastSec = -1; secCount = 0;
    foreach (seen[j]) if (seen[j] == 8'h7D) begin lastSec = j; secCount++; end
    checkEq("ovrSecCnt", secCount, 2);
    checkEq("ovrLen", seen.size(), lastSec + 33);
    if (lastSec >= 0 && seen.size() == lastSec + 33) begin
      for (int k = 0; k < 32; k++)
        checkEq("ovrBit", seen[lastSec + 1 + k], valB[31 - k] ? 8'h71 : 8'h70);
    end
    cycle(0, 0, '0, 0, 8'h00, '0, 1);
    checkEq("ovrClr", todOverrun, 1'b0);

    // Reset while the fifth shift bit is on the output.
    seen.delete();
    cycle(0, 1, 32'hFFFF_0000, 0, 8'h00, '0, 0);
    shiftCount = 0; cyc = 0;
    while (shiftCount < 5 && cyc < 100) begin
      runIdle(1);
      cyc++;
      if (evCode == 8'h70 || evCode == 8'h71) shiftCount++;
    end
    checkEq("rst5wait", shiftCount, 5);
    rst = 1;
    #1;
    checkEq("rstMidCode", evCode, 8'h00);
    checkEq("rstMidBusy", todBusy, 1'b0);
    modelReset();
    @(negedge clk);
    rst = 0;
    checkAll();
    seen.delete();
    runIdle(100);
    checkEq("rstNoResume", seen.size(), 0);
    checkEq("rstIdleBusy", todBusy, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit [N-1:0] hw;
      for (int b = 0; b < N; b++) hw[b] = ($urandom_range(0, 7) == 0);
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0, $urandom,
            $urandom_range(0, 9) < 3, 8'($urandom_range(1, 255)), hw,
            $urandom_range(0, 19) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
